// File: rtl/nine_segment_frame_player.sv
// nine_segment_frame_player: stores up to DEPTH 9-segment frames and plays them
// back on a registered segment output, each frame held dwell*TICK_DIV cycles.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   wr_valid_i/wr_data_i    frame write request and pattern (bit 8 top-left, bit 0 bottom-right)
//   wr_ready_o              buffer accepts a write this cycle
//   clear_i                 empty the buffer and abort playback
//   start_i/stop_i          playback start/stop pulses
//   loop_i/dwell_i          repeat flag and dwell ticks per frame, sampled on accepted start
//   segments_o              registered pattern for the downstream scanner
//   busy_o, done_o          playing / one-cycle end-of-playback pulse
//   frame_count_o           number of stored frames
module nine_segment_frame_player #(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 1000
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     wr_valid_i,
    input  logic [8:0]               wr_data_i,
    output logic                     wr_ready_o,
    input  logic                     clear_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     loop_i,
    input  logic [7:0]               dwell_i,
    output logic [8:0]               segments_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   frame_count_o,
    output logic                     done_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {IDLE, SHOW} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] idx_q, idx_d, nxt_idx;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    dw_q, dw_d, dwell_q, dwell_d;
    logic          loop_q, loop_d;
    logic [8:0]    seg_q, seg_d;
    logic          done_q, done_d;
    logic [8:0]    mem_q [DEPTH];
    logic          wr_en, tick, frame_end, last;

    assign wr_ready_o    = (state_q == IDLE) && !clear_i && (count_q < CW'(DEPTH));
    assign wr_en         = wr_valid_i && wr_ready_o;
    assign segments_o    = seg_q;
    assign busy_o        = (state_q == SHOW);
    assign frame_count_o = count_q;
    assign done_o        = done_q;

    // A frame ends on the tick that completes its last dwell tick.
    assign tick      = (pre_q == PW'(TICK_DIV - 1));
    assign frame_end = tick && (dw_q == dwell_q - 8'd1);
    assign last      = ({1'b0, idx_q} == count_q - CW'(1));
    assign nxt_idx   = last ? '0 : idx_q + IW'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        pre_d   = pre_q;
        dw_d    = dw_q;
        dwell_d = dwell_q;
        loop_d  = loop_q;
        seg_d   = seg_q;
        done_d  = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
            count_d = '0;
            idx_d   = '0;
            pre_d   = '0;
            dw_d    = '0;
            seg_d   = '0;
        end else if (state_q == IDLE) begin
            if (wr_en) count_d = count_q + CW'(1);
            if (start_i && count_q != '0) begin
                state_d = SHOW;
                loop_d  = loop_i;
                dwell_d = (dwell_i == 8'd0) ? 8'd1 : dwell_i;
                idx_d   = '0;
                pre_d   = '0;
                dw_d    = '0;
                seg_d   = mem_q[0];
            end
        end else begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick) dw_d = frame_end ? 8'd0 : dw_q + 8'd1;
            // stop and a natural non-looping end share this path, so one done pulse
            if (stop_i || (frame_end && last && !loop_q)) begin
                state_d = IDLE;
                idx_d   = '0;
                pre_d   = '0;
                dw_d    = '0;
                seg_d   = '0;
                done_d  = 1'b1;
            end else if (frame_end) begin
                idx_d = nxt_idx;
                seg_d = mem_q[nxt_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            pre_q   <= '0;
            dw_q    <= '0;
            dwell_q <= 8'd1;
            loop_q  <= 1'b0;
            seg_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            dw_q    <= dw_d;
            dwell_q <= dwell_d;
            loop_q  <= loop_d;
            seg_q   <= seg_d;
            done_q  <= done_d;
        end
    end

    // Frame storage is left uninitialised; frame_count gates what is reachable.
    always_ff @(posedge clk_i) begin
        if (wr_en && !reset_i) mem_q[count_q[IW-1:0]] <= wr_data_i;
    end
endmodule

// File: doc/nine_segment_frame_player.md
NINE_SEGMENT_FRAME_PLAYER -- requirements
Module: nine_segment_frame_player

Interface
REQ-001 Parameter: DEPTH, 8, number of 9-bit frames in the frame buffer (power of 2, 2..16).
REQ-002 Parameter: TICK_DIV, 1000, clk cycles per dwell tick (>=1).
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: wr_valid  in  1  frame write request.
REQ-006 Port: wr_data  in  9  frame pattern, bit 8 = top-left segment, bit 0 = bottom-right, row-major.
REQ-007 Port: wr_ready  out  1  frame buffer can accept a write this cycle.
REQ-008 Port: clear  in  1  empty the frame buffer, abort playback.
REQ-009 Port: start  in  1  single-cycle pulse, begin playback.
REQ-010 Port: stop  in  1  single-cycle pulse, end playback.
REQ-011 Port: loop  in  1  repeat playback; sampled only on accepted start.
REQ-012 Port: dwell  in  8  dwell ticks per frame; sampled only on accepted start; 0 treated as 1.
REQ-013 Port: segments  out  9  registered 9-segment pattern for the downstream row/column scanner.
REQ-014 Port: busy  out  1  high while in state SHOW.
REQ-015 Port: frame_count  out  clog2(DEPTH)+1  number of stored frames.
REQ-016 Port: done  out  1  one-cycle pulse at playback end.

Function
REQ-017 States: IDLE, SHOW; encoding free; no other reachable states.
REQ-018 wr_ready = !busy && !clear && frame_count < DEPTH (combinational).
REQ-019 Write accepted when wr_valid && wr_ready: wr_data stored at index frame_count, frame_count increments next cycle.
REQ-020 Write with wr_valid high while wr_ready low: dropped silently, no state change.
REQ-021 clear (any state): frame_count <= 0, state <= IDLE, segments <= 0, busy <= 0, done stays 0; clear wins over simultaneous write, start, stop.
REQ-022 IDLE: start with frame_count == 0 ignored; start with frame_count > 0 accepted: latch loop, dwell (0->1), index <= 0, prescaler and dwell counter <= 0, state <= SHOW.
REQ-023 Start latency: start accepted in cycle N -> busy = 1 and segments = frame[0] from cycle N+1.
REQ-024 SHOW: prescaler counts 0..TICK_DIV-1 and emits a tick on wrap; dwell counter advances per tick.
REQ-025 Each frame holds on segments for exactly dwell*TICK_DIV cycles, then the next frame appears on the following cycle.
REQ-026 End of last frame (index == frame_count-1), loop latched 1: index wraps to 0, playback continues, no done.
REQ-027 End of last frame, loop latched 0: state <= IDLE, segments <= 0, busy <= 0, done = 1 for exactly one cycle.
REQ-028 stop in SHOW: same as REQ-027 on the next cycle, regardless of dwell position; stop in IDLE ignored.
REQ-029 start in SHOW ignored (no restart, no re-sampling of loop/dwell).
REQ-030 Buffer contents are not consumed by playback; frames persist for repeated starts until clear or reset.
REQ-031 stop and natural end in the same cycle: single done pulse.
REQ-032 Frame contents beyond frame_count are never driven on segments.

Reset
REQ-033 reset in cycle N -> from N+1: state IDLE, segments = 0, busy = 0, done = 0, frame_count = 0, wr_ready = 1, prescaler/dwell counter/index = 0.
REQ-034 reset mid-playback aborts without done pulse; reset has priority over every other input.
REQ-035 Frame memory contents need not be cleared by reset; frame_count = 0 makes them unreachable.

Verification (TICK_DIV = 2, DEPTH = 4)
REQ-036 Write 9'h1FF, 9'h000, 9'h155; start, dwell=2, loop=0 -> segments 1FF for 4 cycles, 000 for 4, 155 for 4, then 0 with done one cycle, busy low.
REQ-037 Write 5 frames back-to-back with wr_valid held -> 4 accepted, frame_count = 4, wr_ready low from 4th acceptance on, 5th dropped.
REQ-038 2 frames, loop=1, dwell=0 -> segments alternate every 2 cycles for >=20 cycles, no done; stop -> segments 0, done pulse next cycle.
REQ-039 start with empty buffer -> busy stays 0, segments 0, no done; write during SHOW -> not accepted, frame_count unchanged.
REQ-040 clear during SHOW together with wr_valid -> next cycle IDLE, frame_count 0, segments 0, no done, write dropped.
REQ-041 reset asserted mid-frame during SHOW -> next cycle all outputs at REQ-033 values, no done pulse.
